core_decode_stage_pipe: RTL and testbench
=========================================

# core_decode_stage_pipe

Pipelined, parametrised successor of the single-cycle decode stage. It decodes one instruction per cycle through `instruction_decode_unit` and reads operands from `core_register_file`. It adds a valid/ready handshake on both sides, a registered output stage and a write-back bypass. A per-register scoreboard stalls issue on read-after-write and write-after-write hazards. It sits between the fetch stage and the execute stage of the core.

## Interface
Parameters:
- `INSTR_W`, default `INSTR_WIDTH` (32): instruction width.
- `DATA_W`, default `DATA_WIDTH` (32): register and immediate width.
- `PC_W`, default `ADDR_WIDTH` (32): width of the PC passed through.
- `NREGS`, default 32: number of architectural registers. x0 is hard-wired to zero.
- `SB_W`, default 2: width of each scoreboard counter. Maximum in-flight writes per register is 2^SB_W−1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  drops the output register and clears the scoreboard.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  instruction accepted this cycle when `in_valid && in_ready`.
- `in_instr`  in  INSTR_W  instruction.
- `in_pc`  in  PC_W  instruction address.
- `rf_we`  in  1  write-back enable.
- `rf_addr`  in  $clog2(NREGS)  write-back register.
- `rf_data`  in  DATA_W  write-back data.
- `out_valid`  out  1  decoded instruction held.
- `out_ready`  in  1  execute stage consumes the instruction.
- `out_ctrl`  out  CTRL_W  packed decode controls, MSB→LSB: {is_branch, imm_use, rd_use, rs2_use, rs1_use, comparator_control, mdu_control, shift_control, alu_control, comparator_op, shift_op, mdu_op, alu_op, mem_op}. CTRL_W is the sum of the package widths.
- `out_imm`, `out_rs1_value`, `out_rs2_value`  out  DATA_W  immediate and operand values.
- `out_rd_addr`  out  $clog2(NREGS)  destination register.
- `out_pc`  out  PC_W  PC of the held instruction.
- `busy`  out  1  some scoreboard counter is nonzero.
- `sb_err`  out  1  registered one-cycle pulse: write-back to a register whose counter is 0.

## Operation
- Decode is combinational on `in_instr`. Operands come from the register file's combinational read ports.
- Bypass: if `rf_we` is high, `rf_addr` equals the source register and the source is not x0, the operand is taken from `rf_data`. Reads of x0 always return 0.
- Scoreboard: one counter `cnt[r]` per register r = 1..NREGS−1.
  - Increment when an instruction with `rd_use` and rd≠0 leaves the output register (`out_valid && out_ready`).
  - Decrement on `rf_we` with `rf_addr`≠0 and `cnt`>0.
  - Increment and decrement of the same register in the same cycle leave it unchanged.
  - `rf_we` with `cnt`=0 still writes the register file, leaves `cnt` at 0 and pulses `sb_err` next cycle.
- A source register s is pending when it is in use and either of these holds:
  - `out_valid` is high, the held instruction has `rd_use` and `out_rd_addr`==s; or
  - `cnt[s]` minus the same-cycle decrement is greater than 0.
- `hazard` is high when any source is pending, or when `rd_use` is set and `cnt[rd]` equals 2^SB_W−1.
- `in_ready = (!out_valid || out_ready) && !hazard && !flush`. `in_ready` may depend on `in_instr`. Upstream `in_valid` must not depend on `in_ready`.
- On acceptance, all `out_*` registers load and `out_valid` is set. Otherwise, if `out_valid && out_ready`, `out_valid` clears.
- `flush` (highest priority):
  - next cycle `out_valid`=0 and every `cnt`=0;
  - nothing is accepted while `flush` is high;
  - a `rf_we` in the same cycle still writes the register file.
- The system issues `flush` only when no younger write-backs remain outstanding.

## Timing
- Reset (asynchronous, `rst_n`=0): `out_valid`=0, all `out_*` data=0, every `cnt`=0, `busy`=0, `sb_err`=0. Register-file contents are not reset.
- Latency is 1 cycle: an instruction accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 instruction per cycle when there is no hazard and `out_ready` is held high.
- A dependent instruction stalls while its producer sits in the output register and while the producer's counter is nonzero. It issues in the same cycle as the producer's write-back, with the operand supplied by the bypass.
- `out_*` holds stable while `out_valid && !out_ready`.
- `busy` is registered and reflects the counters after the current edge.

## Test plan
- Reset mid-stream: drop `rst_n` while `out_valid`=1 and a counter is nonzero → `out_valid`, `busy` and `sb_err` are 0 immediately, before the next edge.
- Back-to-back independent instructions: 0x00500093 (addi x1,x0,5) then 0x00A00113 (addi x2,x0,10), `out_ready`=1 → two consecutive `out_valid` cycles, `out_imm` = 5 then 10, `cnt[1]`=`cnt[2]`=1.
- Read-after-write stall: addi x1 followed by 0x00108133 (add x2,x1,x1) → `in_ready`=0 until `rf_we`=1, `rf_addr`=1, `rf_data`=5. In that cycle `in_ready`=1 and the add issues with `out_rs1_value`=`out_rs2_value`=5.
- Output backpressure: `out_ready`=0 for 3 cycles → `out_*` stable and `in_ready`=0. On release, the next instruction loads in the following cycle.
- Counter saturation (SB_W=2): four writes to x3 without write-back → the fourth is stalled. After one `rf_we` to x3 it issues. A `rf_we` to x5 with `cnt[5]`=0 pulses `sb_err` for 1 cycle.
- Flush: `flush`=1 while `out_valid`=1 and `cnt[1]`=2 → next cycle `out_valid`=0, `busy`=0, and a previously stalled dependent instruction is accepted.

Source files
------------

// File: rtl/core_decode_stage_pipe.sv
// Pipelined decode stage: decode, register read with write-back bypass,
// registered output and a per-register hazard scoreboard.
package core_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int MEM_OP_W = 2;
  localparam int ALU_OP_W = 1;
  localparam int MDU_OP_W = 1;
  localparam int SHIFT_OP_W = 1;
  localparam int CMP_OP_W = 1;
  localparam int ALU_CTRL_W = 4;
  localparam int SHIFT_CTRL_W = 2;
  localparam int MDU_CTRL_W = 3;
  localparam int CMP_CTRL_W = 3;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef struct packed {
    logic is_branch;
    logic imm_use;
    logic rd_use;
    logic rs2_use;
    logic rs1_use;
    logic [CMP_CTRL_W-1:0] comparator_control;
    logic [MDU_CTRL_W-1:0] mdu_control;
    logic [SHIFT_CTRL_W-1:0] shift_control;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [CMP_OP_W-1:0] comparator_op;
    logic [SHIFT_OP_W-1:0] shift_op;
    logic [MDU_OP_W-1:0] mdu_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic [MEM_OP_W-1:0] mem_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
endpackage

module core_decode_stage_pipe
  import core_pkg::*;
#(
  parameter int INSTR_W = INSTR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int PC_W = ADDR_WIDTH,
  parameter int NREGS = 32,
  parameter int SB_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic rf_we,
  input  logic [$clog2(NREGS)-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_rs1_value,
  output logic [DATA_W-1:0] out_rs2_value,
  output logic [$clog2(NREGS)-1:0] out_rd_addr,
  output logic [PC_W-1:0] out_pc,
  output logic busy,
  output logic sb_err
);
  localparam int AW = $clog2(NREGS);
  localparam int SB_MAX = (1 << SB_W) - 1;

  logic [31:0] ins;
  logic [31:0] imm32;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  ctrl_t c;
  ctrl_t ctrl_q;
  logic [DATA_W-1:0] imm;

  assign ins = 32'(in_instr);
  assign opc = ins[6:0];
  assign f3 = ins[14:12];
  assign f7 = ins[31:25];
  assign rd = ins[7 +: AW];
  assign rs1 = ins[15 +: AW];
  assign rs2 = ins[20 +: AW];

  always_comb begin
    c = '0;
    imm32 = '0;
    c.alu_control = {f7[5], f3};
    c.shift_control = {f7[5], f3[2]};
    c.mdu_control = f3;
    c.comparator_control = f3;
    unique case (1'b1)
      opc == OP_LUI || opc == OP_AUIPC: begin
        c.rd_use = 1'b1;
        c.imm_use = 1'b1;
        c.alu_op = 1'b1;
        imm32 = {ins[31:12], 12'b0};
      end
      opc == OP_JAL: begin
        c.rd_use = 1'b1;
        c.imm_use = 1'b1;
        c.is_branch = 1'b1;
        imm32 = {{12{ins[31]}}, ins[19:12],
                 ins[20], ins[30:21], 1'b0};
      end
      opc == OP_JALR: begin
        c.rd_use = 1'b1;
        c.rs1_use = 1'b1;
        c.imm_use = 1'b1;
        c.is_branch = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      opc == OP_BRANCH: begin
        c.rs1_use = 1'b1;
        c.rs2_use = 1'b1;
        c.imm_use = 1'b1;
        c.is_branch = 1'b1;
        c.comparator_op = 1'b1;
        imm32 = {{20{ins[31]}}, ins[7],
                 ins[30:25], ins[11:8], 1'b0};
      end
      opc == OP_LOAD: begin
        c.rd_use = 1'b1;
        c.rs1_use = 1'b1;
        c.imm_use = 1'b1;
        c.alu_op = 1'b1;
        c.mem_op = 2'b01;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      opc == OP_STORE: begin
        c.rs1_use = 1'b1;
        c.rs2_use = 1'b1;
        c.imm_use = 1'b1;
        c.alu_op = 1'b1;
        c.mem_op = 2'b10;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      opc == OP_IMM: begin
        c.rd_use = 1'b1;
        c.rs1_use = 1'b1;
        c.imm_use = 1'b1;
        c.shift_op = f3[1:0] == 2'b01;
        c.alu_op = !(f3[1:0] == 2'b01);
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      opc == OP_REG: begin
        c.rd_use = 1'b1;
        c.rs1_use = 1'b1;
        c.rs2_use = 1'b1;
        c.mdu_op = f7 == 7'h01;
        c.shift_op = f7 != 7'h01 && f3[1:0] == 2'b01;
        c.alu_op = f7 != 7'h01 && f3[1:0] != 2'b01;
      end
      default: ;
    endcase
  end

  assign imm = DATA_W'($signed(imm32));

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  always_ff @(posedge clk) begin
    if (rf_we && rf_addr != '0) regs[rf_addr] <= rf_data;
  end

  // same-cycle write-back wins over the stored value
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0)
      rs1_val = (rf_we && rf_addr == rs1) ? rf_data : regs[rs1];
    if (rs2 != '0)
      rs2_val = (rf_we && rf_addr == rs2) ? rf_data : regs[rs2];
  end

  logic [SB_W-1:0] cnt [NREGS];
  logic [SB_W-1:0] cnt_nxt [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  logic busy_nxt;
  logic err;
  logic fire_in;
  logic fire_out;
  logic held_rd;
  logic p1;
  logic p2;
  logic sat;
  logic hazard;
  logic [SB_W:0] rd_load;

  assign fire_out = out_valid && out_ready;
  assign held_rd = out_valid && ctrl_q.rd_use;

  always_comb begin
    busy_nxt = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = fire_out && ctrl_q.rd_use && r != 0
               && out_rd_addr == AW'(r);
      dec[r] = rf_we && r != 0 && rf_addr == AW'(r)
               && cnt[r] != '0;
      cnt_nxt[r] = flush ? '0
                 : cnt[r] + SB_W'(inc[r]) - SB_W'(dec[r]);
      busy_nxt = busy_nxt | (cnt_nxt[r] != '0);
    end
    err = rf_we && rf_addr != '0 && cnt[rf_addr] == '0;
  end

  assign p1 = c.rs1_use && rs1 != '0
           && ((held_rd && out_rd_addr == rs1)
           || (cnt[rs1] - SB_W'(dec[rs1])) != '0);
  assign p2 = c.rs2_use && rs2 != '0
           && ((held_rd && out_rd_addr == rs2)
           || (cnt[rs2] - SB_W'(dec[rs2])) != '0);

  // the held producer will bump its counter as it leaves
  assign rd_load = {1'b0, cnt[rd]}
                 + (SB_W+1)'(held_rd && out_rd_addr == rd);
  assign sat = c.rd_use && rd != '0
            && rd_load >= (SB_W+1)'(SB_MAX);

  assign hazard = p1 || p2 || sat;
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign fire_in = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      busy <= 1'b0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
      busy <= busy_nxt;
      sb_err <= err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl_q <= '0;
      out_imm <= '0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
      out_rd_addr <= '0;
      out_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_in) begin
      out_valid <= 1'b1;
      ctrl_q <= c;
      out_imm <= imm;
      out_rs1_value <= rs1_val;
      out_rs2_value <= rs2_val;
      out_rd_addr <= rd;
      out_pc <= in_pc;
    end else if (fire_out) begin
      out_valid <= 1'b0;
    end
  end

  assign out_ctrl = ctrl_q;
endmodule

// File: tb/tb_core_decode_stage_pipe.sv
// Bench for core_decode_stage_pipe: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_core_decode_stage_pipe;
  localparam int CW = core_pkg::CTRL_W;
  localparam int K_ADDI = 0;
  localparam int K_ADD = 1;
  localparam int K_LUI = 2;
  localparam int K_SW = 3;
  localparam int K_BEQ = 4;
  localparam int K_JAL = 5;
  localparam int SAT = 3;

  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [31:0] in_instr = 0;
  logic [31:0] in_pc = 0;
  logic rf_we = 0;
  logic [4:0] rf_addr = 0;
  logic [31:0] rf_data = 0;
  logic out_valid;
  logic out_ready = 0;
  logic [CW-1:0] out_ctrl;
  logic [31:0] out_imm;
  logic [31:0] out_rs1_value;
  logic [31:0] out_rs2_value;
  logic [4:0] out_rd_addr;
  logic [31:0] out_pc;
  logic busy;
  logic sb_err;

  int compared = 0;
  int mismatched = 0;

  core_decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_imm(out_imm),
    .out_rs1_value(out_rs1_value),
    .out_rs2_value(out_rs2_value),
    .out_rd_addr(out_rd_addr), .out_pc(out_pc),
    .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r1;
    bit r2;
    bit rd;
    bit iu;
    int s1;
    int s2;
    int d;
    logic [31:0] imm;
  } info_t;

  info_t cur;
  info_t m_held;
  int m_cnt [32];
  logic [31:0] m_rf [32];
  bit m_valid;
  bit m_err;
  bit m_busy;
  logic [31:0] m_v1;
  logic [31:0] m_v2;
  logic [31:0] m_pc;

  task automatic model_reset();
    m_valid = 0;
    m_err = 0;
    m_busy = 0;
    m_held = '{default: 0};
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  function automatic bit pend(int s);
    int left;
    if (s == 0) return 0;
    left = m_cnt[s];
    if (rf_we && rf_addr == s && m_cnt[s] > 0) left--;
    return (m_valid && m_held.rd && m_held.d == s) || left > 0;
  endfunction

  function automatic bit model_ready();
    bit hz;
    int load;
    hz = (cur.r1 && pend(cur.s1)) || (cur.r2 && pend(cur.s2));
    if (cur.rd && cur.d != 0) begin
      load = m_cnt[cur.d];
      if (m_valid && m_held.rd && m_held.d == cur.d) load++;
      if (load >= SAT) hz = 1;
    end
    return (!m_valid || out_ready) && !flush && !hz;
  endfunction

  function automatic logic [31:0] opnd(int s);
    if (s == 0) return 0;
    if (rf_we && rf_addr == s) return rf_data;
    return m_rf[s];
  endfunction

  task automatic model_edge();
    bit acc;
    bit leave;
    int nc [32];
    logic [31:0] v1;
    logic [31:0] v2;
    acc = in_valid && model_ready();
    leave = m_valid && out_ready;
    v1 = opnd(cur.s1);
    v2 = opnd(cur.s2);
    m_err = rf_we && rf_addr != 0 && m_cnt[rf_addr] == 0;
    nc = m_cnt;
    if (leave && m_held.rd && m_held.d != 0) nc[m_held.d]++;
    if (rf_we && rf_addr != 0 && m_cnt[rf_addr] > 0)
      nc[rf_addr]--;
    if (flush) nc = '{default: 0};
    m_cnt = nc;
    if (rf_we && rf_addr != 0) m_rf[rf_addr] = rf_data;
    m_busy = 0;
    for (int r = 0; r < 32; r++) if (m_cnt[r] > 0) m_busy = 1;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_held = cur;
      m_v1 = v1;
      m_v2 = v2;
      m_pc = in_pc;
    end else if (leave) m_valid = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(int k, int d, int a, int b, int imm);
    logic [31:0] v;
    logic [4:0] d5;
    logic [4:0] a5;
    logic [4:0] b5;
    v = imm;
    d5 = 5'(d);
    a5 = 5'(a);
    b5 = 5'(b);
    cur = '{default: 0};
    cur.imm = v;
    case (k)
      K_ADDI: begin
        in_instr = {v[11:0], a5, 3'b000, d5, 7'h13};
        cur.r1 = 1; cur.rd = 1; cur.iu = 1;
        cur.s1 = a; cur.d = d;
      end
      K_ADD: begin
        in_instr = {7'h00, b5, a5, 3'b000, d5, 7'h33};
        cur.r1 = 1; cur.r2 = 1; cur.rd = 1;
        cur.s1 = a; cur.s2 = b; cur.d = d;
      end
      K_LUI: begin
        in_instr = {v[31:12], d5, 7'h37};
        cur.imm = {v[31:12], 12'h000};
        cur.rd = 1; cur.iu = 1; cur.d = d;
      end
      K_SW: begin
        in_instr = {v[11:5], b5, a5, 3'b010, v[4:0], 7'h23};
        cur.r1 = 1; cur.r2 = 1; cur.iu = 1;
        cur.s1 = a; cur.s2 = b;
      end
      K_BEQ: begin
        in_instr = {v[12], v[10:5], b5, a5, 3'b000,
                    v[4:1], v[11], 7'h63};
        cur.r1 = 1; cur.r2 = 1; cur.iu = 1;
        cur.s1 = a; cur.s2 = b;
      end
      default: begin
        in_instr = {v[20], v[10:1], v[11], v[19:12], d5, 7'h6f};
        cur.rd = 1; cur.iu = 1; cur.d = d;
      end
    endcase
  endtask

  task automatic writeback(int r, logic [31:0] data);
    rf_we = 1;
    rf_addr = 5'(r);
    rf_data = data;
    tick();
    rf_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sb_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got v=%b b=%b e=%b want 000",
               out_valid, busy, sb_err);
    end
    compared++;
    if (out_imm !== 0 || out_rs1_value !== 0 || out_pc !== 0
        || out_ctrl !== 0 || out_rd_addr !== 0) begin
      mismatched++;
      $display("FAIL reset_data: got imm=%h pc=%h ctrl=%h want 0",
               out_imm, out_pc, out_ctrl);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    model_reset();
    #1 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic init_rf();
    for (int r = 1; r < 32; r++) writeback(r, $urandom);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    in_valid = 1;
    set_instr(K_ADDI, 1, 0, 0, 5);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ready0: got %b want 1", in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_imm !== 32'd5
        || out_rd_addr !== 5'd1) begin
      mismatched++;
      $display("FAIL b2b_first: got v=%b imm=%0d rd=%0d want 1/5/1",
               out_valid, out_imm, out_rd_addr);
    end
    set_instr(K_ADDI, 2, 0, 0, 10);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ready1: got %b want 1", in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_imm !== 32'd10) begin
      mismatched++;
      $display("FAIL b2b_second: got v=%b imm=%0d want 1/10",
               out_valid, out_imm);
    end
    in_valid = 0;
    tick();
    compared++;
    if (busy !== 1'b1 || m_cnt[1] != 1 || m_cnt[2] != 1) begin
      mismatched++;
      $display("FAIL b2b_busy: got %b want 1", busy);
    end
    writeback(1, 32'd5);
    writeback(2, 32'd10);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_drain: got busy %b want 0", busy);
    end
  endtask

  task automatic test_raw_stall();
    out_ready = 1;
    in_valid = 1;
    set_instr(K_ADDI, 1, 0, 0, 5);
    tick();
    set_instr(K_ADD, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL raw_stall%0d: got %b want 0", i, in_ready);
      end
      tick();
    end
    rf_we = 1;
    rf_addr = 1;
    rf_data = 32'd5;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL raw_bypass_ready: got %b want 1", in_ready);
    end
    tick();
    rf_we = 0;
    compared++;
    if (out_valid !== 1'b1 || out_rs1_value !== 32'd5
        || out_rs2_value !== 32'd5 || out_rd_addr !== 5'd2) begin
      mismatched++;
      $display("FAIL raw_operands: got v=%b a=%0d b=%0d rd=%0d want 1/5/5/2",
               out_valid, out_rs1_value, out_rs2_value, out_rd_addr);
    end
    in_valid = 0;
    tick();
    writeback(2, 32'd10);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL raw_drain: got busy %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1;
    in_valid = 1;
    in_pc = 32'h100;
    set_instr(K_ADDI, 3, 0, 0, 7);
    tick();
    out_ready = 0;
    in_pc = 32'h104;
    set_instr(K_ADDI, 4, 0, 0, 9);
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_ready%0d: got %b want 0", i, in_ready);
      end
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_imm !== 32'd7
          || out_pc !== 32'h100 || out_rd_addr !== 5'd3) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got v=%b imm=%0d pc=%h want 1/7/100",
                 i, out_valid, out_imm, out_pc);
      end
    end
    out_ready = 1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: got %b want 1", in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_imm !== 32'd9
        || out_pc !== 32'h104) begin
      mismatched++;
      $display("FAIL bp_next: got v=%b imm=%0d pc=%h want 1/9/104",
               out_valid, out_imm, out_pc);
    end
    in_valid = 0;
    tick();
    writeback(3, 32'd7);
    writeback(4, 32'd9);
  endtask

  task automatic test_saturation();
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(K_ADDI, 3, 0, 0, i + 1);
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL sat_issue%0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    set_instr(K_ADDI, 3, 0, 0, 4);
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_fourth: got %b want 0", in_ready);
    end
    tick();
    rf_we = 1;
    rf_addr = 3;
    rf_data = 32'd1;
    #1;
    compared++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_full: got rdy=%b busy=%b want 0/1",
               in_ready, busy);
    end
    tick();
    rf_we = 0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_after_wb: got %b want 1", in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_imm !== 32'd4) begin
      mismatched++;
      $display("FAIL sat_issued: got v=%b imm=%0d want 1/4",
               out_valid, out_imm);
    end
    in_valid = 0;
    tick();
    writeback(5, 32'd55);
    compared++;
    if (sb_err !== 1'b1) begin
      mismatched++;
      $display("FAIL sb_err_pulse: got %b want 1", sb_err);
    end
    tick();
    compared++;
    if (sb_err !== 1'b0) begin
      mismatched++;
      $display("FAIL sb_err_clear: got %b want 0", sb_err);
    end
    for (int i = 0; i < 3; i++) writeback(3, 32'd3);
    compared++;
    if (busy !== 1'b0 || sb_err !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_drain: got busy=%b err=%b want 0/0",
               busy, sb_err);
    end
  endtask

  task automatic test_flush();
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(K_ADDI, 1, 0, 0, 20 + i);
      tick();
    end
    set_instr(K_ADD, 2, 1, 1, 0);
    #1;
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || m_cnt[1] != 2) begin
      mismatched++;
      $display("FAIL flush_pre: got rdy=%b v=%b want 0/1",
               in_ready, out_valid);
    end
    flush = 1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_blocks: got %b want 0", in_ready);
    end
    tick();
    flush = 0;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_clear: got v=%b busy=%b want 0/0",
               out_valid, busy);
    end
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_release: got %b want 1", in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_rs1_value !== m_rf[1]
        || out_rd_addr !== 5'd2) begin
      mismatched++;
      $display("FAIL flush_dep: got v=%b a=%h want 1/%h",
               out_valid, out_rs1_value, m_rf[1]);
    end
    in_valid = 0;
    tick();
    writeback(2, 32'd2);
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        K_ADDI, K_SW:
          set_instr(k, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7),
                    int'($urandom_range(0, 4095)) - 2048);
        K_BEQ:
          set_instr(k, 0, $urandom_range(0, 7), $urandom_range(0, 7),
                    (int'($urandom_range(0, 4095)) - 2048) * 2);
        K_LUI:
          set_instr(k, $urandom_range(0, 7), 0, 0,
                    int'($urandom & 32'hffff_f000));
        K_JAL:
          set_instr(k, $urandom_range(0, 7), 0, 0,
                    (int'($urandom_range(0, 1048575)) - 524288) * 2);
        default:
          set_instr(k, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), 0);
      endcase
      in_valid = $urandom_range(0, 3) != 0;
      in_pc = $urandom;
      out_ready = $urandom_range(0, 4) != 0;
      flush = $urandom_range(0, 99) == 0;
      rf_we = $urandom_range(0, 9) < 4;
      if (rf_we) begin
        int t;
        t = 0;
        for (int r = 1; r < 8; r++)
          if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) t = r;
        if (t == 0) t = $urandom_range(1, 7);
        rf_addr = 5'(t);
        rf_data = $urandom;
      end
      #1;
      compared++;
      if (in_ready !== model_ready()) begin
        mismatched++;
        $display("FAIL rnd_in_ready @%0d: got %b want %b",
                 i, in_ready, model_ready());
      end
      tick();
      compared++;
      if (out_valid !== m_valid || busy !== m_busy
          || sb_err !== m_err) begin
        mismatched++;
        $display("FAIL rnd_flags @%0d: got v=%b b=%b e=%b want %b%b%b",
                 i, out_valid, busy, sb_err, m_valid, m_busy, m_err);
      end
      if (m_valid) begin
        compared++;
        if (out_pc !== m_pc
            || out_ctrl[CW-3 -: 3] !== {m_held.rd, m_held.r2, m_held.r1}
            || (m_held.rd && out_rd_addr !== 5'(m_held.d))
            || (m_held.iu && out_imm !== m_held.imm)) begin
          mismatched++;
          $display("FAIL rnd_decode @%0d: got pc=%h imm=%h rd=%0d want %h/%h/%0d",
                   i, out_pc, out_imm, out_rd_addr, m_pc, m_held.imm,
                   m_held.d);
        end
        compared++;
        if ((m_held.r1 && out_rs1_value !== m_v1)
            || (m_held.r2 && out_rs2_value !== m_v2)) begin
          mismatched++;
          $display("FAIL rnd_operands @%0d: got %h/%h want %h/%h",
                   i, out_rs1_value, out_rs2_value, m_v1, m_v2);
        end
      end
    end
    flush = 0;
    rf_we = 0;
    in_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1;
    in_valid = 1;
    set_instr(K_ADDI, 1, 0, 0, 3);
    tick();
    set_instr(K_ADDI, 6, 0, 0, 4);
    tick();
    in_valid = 0;
    compared++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_pre: got v=%b busy=%b want 1/1",
               out_valid, busy);
    end
    rst_n = 0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sb_err !== 1'b0
        || out_imm !== 0) begin
      mismatched++;
      $display("FAIL mid_reset: got v=%b b=%b e=%b imm=%h want 0",
               out_valid, busy, sb_err, out_imm);
    end
    model_reset();
    #2 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cur = '{default: 0};
    test_reset();
    init_rf();
    test_back_to_back();
    test_raw_stall();
    test_backpressure();
    test_saturation();
    test_flush();
    test_random();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
